// File: rtl/manchester_frame_tx_if.sv
// Valid/ready word-source handshake into the Manchester frame transmitter.
//   tx_valid : source has a word
//   tx_ready : transmitter FIFO can accept a word
//   tx_data  : payload word, DATA_BITS wide
interface manchester_frame_tx_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic                 tx_valid;
    logic                 tx_ready;
    logic [DATA_BITS-1:0] tx_data;

    modport master (output tx_valid, output tx_data, input tx_ready);
    modport slave  (input tx_valid, input tx_data, output tx_ready);
endinterface

// File: rtl/manchester_frame_tx.sv
// Manchester-encoded serial frame transmitter with an input FIFO.
// Frame: encoded start bit (logic 1), DATA_BITS encoded data bits, optional
// encoded parity bit, then STOP_BITS unencoded periods at IDLE_LEVEL.
// Queued words are sent back to back with no idle clocks between frames.
//   clk        : system clock, rising edge
//   reset      : asynchronous active-high reset
//   s_if       : word source handshake (slave side; tx_ready is registered)
//   tx         : serial line, registered
//   busy       : frame in progress, registered
//   fifo_level : FIFO occupancy, registered
module manchester_frame_tx #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_EN  = 0,
    parameter int unsigned PARITY_ODD = 0,
    parameter int unsigned MSB_FIRST  = 0,
    parameter int unsigned POLARITY   = 0,
    parameter int unsigned IDLE_LEVEL = 0,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned CLK_FREQ   = 18_750_000,
    parameter int unsigned BAUDRATE   = 115200
) (
    input  logic                          clk,
    input  logic                          reset,
    manchester_frame_tx_if.slave          s_if,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int unsigned FULLBAUD = CLK_FREQ / BAUDRATE;
    localparam int unsigned HALF     = FULLBAUD / 2;
    localparam int unsigned CNT_W    = $clog2(FULLBAUD);
    localparam int unsigned IDX_W    = $clog2(DATA_BITS);
    localparam int unsigned PTR_W    = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W    = PTR_W + 1;
    localparam logic        POL      = 1'(POLARITY);
    localparam logic        IDLE     = 1'(IDLE_LEVEL);
    localparam logic        ODD      = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP
    } state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [IDX_W-1:0]     bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 parity_bit;
    logic                 line_bit;

    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 ready_q;

    logic                 push_c;
    logic                 pop_c;
    logic                 period_end_c;
    logic                 out_bit_c;
    logic [DATA_BITS-1:0] shift_c;
    logic [DATA_BITS-1:0] head_c;
    logic [LVL_W-1:0]     level_nxt_c;

    assign s_if.tx_ready = ready_q;
    assign push_c        = s_if.tx_valid & ready_q;
    assign head_c        = mem[rd_ptr];
    assign period_end_c  = (cnt == CNT_W'(FULLBAUD - 1));

    // Pop either from idle or on the very last stop clock (gapless chaining).
    assign pop_c = (fifo_level != '0) &&
                   ((state == S_IDLE) ||
                    ((state == S_STOP) && period_end_c &&
                     (bit_idx == IDX_W'(STOP_BITS - 1))));

    // Next data bit sits at the shift-register end selected by bit order.
    assign out_bit_c = (MSB_FIRST != 0) ? shreg[DATA_BITS-1] : shreg[0];
    assign shift_c   = (MSB_FIRST != 0) ? {shreg[DATA_BITS-2:0], 1'b0}
                                        : {1'b0, shreg[DATA_BITS-1:1]};

    // FIFO occupancy after this edge's push/pop.
    always_comb begin
        level_nxt_c = fifo_level;
        if (push_c && !pop_c) begin
            level_nxt_c = fifo_level + LVL_W'(1);
        end else if (!push_c && pop_c) begin
            level_nxt_c = fifo_level - LVL_W'(1);
        end
    end

    // FIFO storage; contents are discarded on reset via the pointers.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= s_if.tx_data;
        end
    end

    // FIFO pointers, level and registered ready.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            ready_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop_c)  rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_level <= level_nxt_c;
            ready_q    <= (level_nxt_c != LVL_W'(FIFO_DEPTH));
        end
    end

    // Frame sequencer. line_bit holds the encoded second half of the current
    // bit; the first half (its inverse) is driven at the bit boundary.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            parity_bit <= 1'b0;
            line_bit   <= 1'b0;
            tx         <= IDLE;
            busy       <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    tx   <= IDLE;
                    busy <= 1'b0;
                    cnt  <= '0;
                end
                S_START, S_DATA, S_PARITY: begin
                    cnt <= period_end_c ? '0 : cnt + CNT_W'(1);
                    if (cnt == CNT_W'(HALF - 1)) begin
                        tx <= line_bit;
                    end
                    if (period_end_c) begin
                        if ((state == S_START) ||
                            ((state == S_DATA) && (bit_idx != IDX_W'(DATA_BITS - 1)))) begin
                            state    <= S_DATA;
                            bit_idx  <= (state == S_START) ? '0 : bit_idx + IDX_W'(1);
                            line_bit <= out_bit_c ^ POL;
                            tx       <= ~(out_bit_c ^ POL);
                            shreg    <= shift_c;
                        end else if ((state == S_DATA) && (PARITY_EN != 0)) begin
                            state    <= S_PARITY;
                            line_bit <= parity_bit ^ POL;
                            tx       <= ~(parity_bit ^ POL);
                        end else begin
                            state   <= S_STOP;
                            bit_idx <= '0;
                            tx      <= IDLE;
                        end
                    end
                end
                S_STOP: begin
                    tx  <= IDLE;
                    cnt <= period_end_c ? '0 : cnt + CNT_W'(1);
                    if (period_end_c) begin
                        if (bit_idx != IDX_W'(STOP_BITS - 1)) begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end else begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    tx    <= IDLE;
                    busy  <= 1'b0;
                end
            endcase

            // Frame load overrides the idle/stop exit; start bit is logic 1.
            if (pop_c) begin
                state      <= S_START;
                cnt        <= '0;
                bit_idx    <= '0;
                shreg      <= head_c;
                parity_bit <= (^head_c) ^ ODD;
                line_bit   <= ~POL;
                tx         <= POL;
                busy       <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_manchester_frame_tx.sv
// Scoreboard bench for manchester_frame_tx: three differently configured
// instances run in parallel against a timeline model of the FIFO/frame
// occupancy and a per-clock waveform built from the frame rules.
module tb_manchester_frame_tx;

    localparam int NC = 3;

    // Config A: defaults at FULLBAUD 16; B: 7 bits, odd parity, MSB first,
    // 2 stop bits; C: inverted polarity, idle high, even parity, FULLBAUD 15.
    localparam int unsigned CLK_A = 1_600_000;
    localparam int unsigned CLK_B = 1_600_000;
    localparam int unsigned CLK_C = 1_500_000;
    localparam int unsigned BAUD  = 100_000;

    if ((CLK_A / BAUD < 4) || (CLK_B / BAUD < 4) || (CLK_C / BAUD < 4)) begin : g_fullbaud_check
        $error("FULLBAUD below 4");
    end

    logic clk;
    logic reset;

    int db[NC], sb[NC], pen[NC], podd[NC], msb[NC], pol[NC], idl[NC], dep[NC], fb[NC], fl[NC];

    logic        vld[NC];
    logic [15:0] dat[NC];
    logic        tx_o[NC];
    logic        busy_o[NC];
    logic        rdy_o[NC];
    logic [7:0]  lvl_o[NC];

    int   mlevel[NC];
    int   rem[NC];
    logic mready[NC];
    logic acc[NC];
    logic [15:0] q0[$];
    logic [15:0] q1[$];
    logic [15:0] q2[$];

    int n_chk = 0;
    int n_fail = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    logic       tx_a, tx_b, tx_c, busy_a, busy_b, busy_c;
    logic [2:0] lvl_a, lvl_b;
    logic [3:0] lvl_c;

    manchester_frame_tx_if #(.DATA_BITS(8)) if_a ();
    manchester_frame_tx_if #(.DATA_BITS(7)) if_b ();
    manchester_frame_tx_if #(.DATA_BITS(8)) if_c ();

    manchester_frame_tx #(
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0), .MSB_FIRST(0),
        .POLARITY(0), .IDLE_LEVEL(0), .FIFO_DEPTH(4), .CLK_FREQ(CLK_A), .BAUDRATE(BAUD)
    ) dut_a (.clk(clk), .reset(reset), .s_if(if_a.slave), .tx(tx_a), .busy(busy_a), .fifo_level(lvl_a));

    manchester_frame_tx #(
        .DATA_BITS(7), .STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(1), .MSB_FIRST(1),
        .POLARITY(0), .IDLE_LEVEL(0), .FIFO_DEPTH(4), .CLK_FREQ(CLK_B), .BAUDRATE(BAUD)
    ) dut_b (.clk(clk), .reset(reset), .s_if(if_b.slave), .tx(tx_b), .busy(busy_b), .fifo_level(lvl_b));

    manchester_frame_tx #(
        .DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0), .MSB_FIRST(0),
        .POLARITY(1), .IDLE_LEVEL(1), .FIFO_DEPTH(8), .CLK_FREQ(CLK_C), .BAUDRATE(BAUD)
    ) dut_c (.clk(clk), .reset(reset), .s_if(if_c.slave), .tx(tx_c), .busy(busy_c), .fifo_level(lvl_c));

    assign if_a.tx_valid = vld[0];
    assign if_b.tx_valid = vld[1];
    assign if_c.tx_valid = vld[2];
    assign if_a.tx_data  = dat[0][7:0];
    assign if_b.tx_data  = dat[1][6:0];
    assign if_c.tx_data  = dat[2][7:0];

    assign tx_o[0] = tx_a;   assign tx_o[1] = tx_b;   assign tx_o[2] = tx_c;
    assign busy_o[0] = busy_a; assign busy_o[1] = busy_b; assign busy_o[2] = busy_c;
    assign rdy_o[0] = if_a.tx_ready; assign rdy_o[1] = if_b.tx_ready; assign rdy_o[2] = if_c.tx_ready;
    assign lvl_o[0] = 8'(lvl_a); assign lvl_o[1] = 8'(lvl_b); assign lvl_o[2] = 8'(lvl_c);

    // ---------------- helpers ----------------
    function automatic void chk(input string name, input int c, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s cfg%0d @%0t: got %0h expected %0h", name, c, $time, act, exp);
        end
    endfunction

    function automatic logic [15:0] mask(input int c);
        return 16'((32'd1 << db[c]) - 32'd1);
    endfunction

    function automatic void qpush(input int c, input logic [15:0] w);
        case (c)
            0: q0.push_back(w);
            1: q1.push_back(w);
            default: q2.push_back(w);
        endcase
    endfunction

    function automatic void qpop(input int c, output logic [15:0] w, output bit ok);
        ok = 1'b0;
        w  = '0;
        case (c)
            0: if (q0.size() > 0) begin w = q0.pop_front(); ok = 1'b1; end
            1: if (q1.size() > 0) begin w = q1.pop_front(); ok = 1'b1; end
            default: if (q2.size() > 0) begin w = q2.pop_front(); ok = 1'b1; end
        endcase
    endfunction

    // Expected line level at clock n of a frame carrying word w.
    function automatic logic exp_level(input int c, input logic [15:0] w, input int n);
        int   p, t;
        logic b;
        p = n / fb[c];
        t = n % fb[c];
        if (p == 0) b = 1'b1;
        else if (p <= db[c]) b = (msb[c] != 0) ? w[db[c] - p] : w[p - 1];
        else if (pen[c] != 0 && p == db[c] + 1) b = (^w) ^ (podd[c] != 0);
        else return idl[c] != 0;
        b = b ^ (pol[c] != 0);
        return (t < fb[c] / 2) ? ~b : b;
    endfunction

    // ---------------- reference timeline model ----------------
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NC; c++) begin
                mlevel[c] <= 0;
                rem[c]    <= 0;
                mready[c] <= 1'b0;
                acc[c]    <= 1'b0;
            end
            q0.delete();
            q1.delete();
            q2.delete();
        end else begin
            for (int c = 0; c < NC; c++) begin
                automatic bit push = vld[c] && mready[c];
                automatic bit pop  = (mlevel[c] != 0) && (rem[c] <= 1);
                automatic int nl   = mlevel[c] + int'(push) - int'(pop);
                acc[c] <= push;
                if (push) qpush(c, dat[c] & mask(c));
                rem[c]    <= pop ? fl[c] : ((rem[c] > 0) ? rem[c] - 1 : 0);
                mlevel[c] <= nl;
                mready[c] <= (nl != dep[c]);
            end
        end
    end

    // ---------------- per-cycle handshake/occupancy checks ----------------
    always @(negedge clk) begin
        if (!reset) begin
            for (int c = 0; c < NC; c++) begin
                chk("busy", c, int'(busy_o[c]), int'(rem[c] != 0));
                chk("fifo_level", c, int'(lvl_o[c]), mlevel[c]);
                chk("tx_ready", c, int'(rdy_o[c]), int'(mready[c]));
                if (rem[c] == 0) chk("idle_tx", c, int'(tx_o[c]), idl[c]);
            end
        end
    end

    // ---------------- frame monitors ----------------
    task automatic mon(input int c);
        logic [15:0] w;
        bit          ok;
        int          bad, first;
        logic        e, fe, fa;
        forever begin
            @(negedge clk);
            if (reset || !busy_o[c]) continue;
            do begin
                qpop(c, w, ok);
                chk("frame_expected", c, int'(ok), 1);
                bad = 0; first = -1; fe = 1'b0; fa = 1'b0;
                for (int n = 0; n < fl[c]; n++) begin
                    if (n > 0) @(negedge clk);
                    if (reset) break;
                    e = exp_level(c, w, n);
                    if (tx_o[c] !== e) begin
                        if (first < 0) begin first = n; fe = e; fa = tx_o[c]; end
                        bad++;
                    end
                end
                if (reset) break;
                if (ok) begin
                    n_chk++;
                    if (bad != 0) begin
                        n_fail++;
                        $display("FAIL frame cfg%0d word %0h: %0d clocks wrong, first at clock %0d tx=%b expected %b",
                                 c, w, bad, first, fa, fe);
                    end
                end
                @(negedge clk);
            end while (!reset && busy_o[c]);
        end
    endtask

    initial begin
        fork
            mon(0);
            mon(1);
            mon(2);
        join
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 right after acceptance.
    task automatic push_word(input int c, input logic [15:0] w);
        vld[c] = 1'b1;
        dat[c] = w;
        for (int i = 0; i < 4000; i++) begin
            tick();
            if (acc[c]) begin
                vld[c] = 1'b0;
                return;
            end
        end
        vld[c] = 1'b0;
        chk("push_accept_timeout", c, 0, 1);
    endtask

    task automatic drain();
        bit done;
        for (int i = 0; i < 20000; i++) begin
            done = 1'b1;
            for (int c = 0; c < NC; c++) if (rem[c] != 0 || mlevel[c] != 0) done = 1'b0;
            if (done) begin
                for (int c = 0; c < NC; c++) chk("idle_after_drain", c, int'(busy_o[c]), 0);
                return;
            end
            tick();
        end
        chk("drain_timeout", 0, 0, 1);
    endtask

    task automatic random_traffic(input int c, input int words);
        for (int i = 0; i < words; i++) begin
            repeat ($urandom_range(0, 200)) tick();
            push_word(c, 16'($urandom));
        end
    endtask

    initial begin
        db   = '{8, 7, 8};   sb  = '{1, 2, 1};   pen = '{0, 1, 1};
        podd = '{0, 1, 0};   msb = '{0, 1, 0};   pol = '{0, 0, 1};
        idl  = '{0, 0, 1};   dep = '{4, 4, 8};
        fb   = '{int'(CLK_A / BAUD), int'(CLK_B / BAUD), int'(CLK_C / BAUD)};
        for (int c = 0; c < NC; c++) fl[c] = (1 + db[c] + pen[c] + sb[c]) * fb[c];
        for (int c = 0; c < NC; c++) begin vld[c] = 1'b0; dat[c] = '0; end

        // Reset values
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int c = 0; c < NC; c++) begin
            chk("reset_tx", c, int'(tx_o[c]), idl[c]);
            chk("reset_ready", c, int'(rdy_o[c]), 0);
            chk("reset_busy", c, int'(busy_o[c]), 0);
            chk("reset_level", c, int'(lvl_o[c]), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        for (int c = 0; c < NC; c++) chk("ready_after_release", c, int'(rdy_o[c]), 1);

        // Single frames, then four more queued behind A's first frame
        fork
            push_word(1, 16'h0055);
            push_word(2, 16'h0001);
            begin
                push_word(0, 16'h00A5);
                push_word(0, 16'h0000);
                push_word(0, 16'h00FF);
                push_word(0, 16'h003C);
                push_word(0, 16'h0081);
                chk("ready_low_when_full", 0, int'(rdy_o[0]), 0);
                chk("level_when_full", 0, int'(lvl_o[0]), 4);
            end
        join
        drain();

        // Random traffic on all instances
        fork
            random_traffic(0, 8);
            random_traffic(1, 8);
            random_traffic(2, 10);
        join
        drain();

        // Simultaneous push and pop at level 2
        push_word(0, 16'h0011);
        push_word(0, 16'h0022);
        push_word(0, 16'h0033);
        for (int i = 0; i < 400 && rem[0] != 1; i++) tick();
        chk("reached_last_clock", 0, rem[0], 1);
        push_word(0, 16'h0044);
        chk("level_push_pop", 0, int'(lvl_o[0]), 2);

        // Valid held with changing data through full and pops
        vld[0] = 1'b1;
        for (int i = 0; i < 700; i++) begin
            dat[0] = 16'($urandom);
            tick();
        end
        vld[0] = 1'b0;
        drain();

        // Reset 50 clocks into a frame with words queued
        fork
            begin push_word(0, 16'h00C3); push_word(0, 16'h005A); push_word(0, 16'h0096); end
            begin push_word(1, 16'h0012); push_word(1, 16'h0034); end
            begin push_word(2, 16'h0078); push_word(2, 16'h009A); end
        join
        for (int i = 0; i < 400 && rem[0] != fl[0] - 50; i++) tick();
        chk("frame_clock_50", 0, rem[0], fl[0] - 50);
        #2;
        reset = 1'b1;
        #1;
        for (int c = 0; c < NC; c++) begin
            chk("abort_tx", c, int'(tx_o[c]), idl[c]);
            chk("abort_busy", c, int'(busy_o[c]), 0);
            chk("abort_level", c, int'(lvl_o[c]), 0);
            chk("abort_ready", c, int'(rdy_o[c]), 0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("ready_before_edge", 0, int'(rdy_o[0]), 0);
        tick();
        for (int c = 0; c < NC; c++) chk("ready_one_edge_after", c, int'(rdy_o[c]), 1);
        repeat (400) tick();
        for (int c = 0; c < NC; c++) chk("no_residual_frame", c, int'(busy_o[c]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
